// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM encoding, the control
// output bundle and sizing constants.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HZ_RUN        = 2'd0,
    HZ_LOAD_STALL = 2'd1,
    HZ_MEM_WAIT   = 2'd2,
    HZ_FLUSH      = 2'd3
  } hz_state_e;

  localparam int DEFAULT_REG_ADDR_W = 3;
  // Wide enough for LOAD_STALL_CYCLES up to 15.
  localparam int LOAD_CNT_W = 4;

  typedef struct packed {
    logic stall_pc;
    logic stall_ifid;
    logic bubble_idex;
    logic flush_ifid;
    logic freeze_pipe;
  } hz_ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
// The master drives stage information and memory status; the slave returns control.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W  = 3,
  parameter int STALL_CNT_W = 16
);
  logic [REG_ADDR_W-1:0]  op1_addr_IFID;
  logic [REG_ADDR_W-1:0]  op2_addr_IFID;
  logic                   op1_used_IFID;
  logic                   op2_used_IFID;
  logic [REG_ADDR_W-1:0]  dest_addr_EX;
  logic                   reg_wr_en_EX;
  logic                   load_true_EX;
  logic                   branch_taken_EX;
  logic                   dmem_req;
  logic                   dmem_ready;
  logic                   perf_clr;
  logic                   stall_PC;
  logic                   stall_IFID;
  logic                   bubble_IDEX;
  logic                   flush_IFID;
  logic                   freeze_pipe;
  logic [1:0]             hz_state;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output op1_addr_IFID, op2_addr_IFID, op1_used_IFID, op2_used_IFID,
           dest_addr_EX, reg_wr_en_EX, load_true_EX, branch_taken_EX,
           dmem_req, dmem_ready, perf_clr,
    input  stall_PC, stall_IFID, bubble_IDEX, flush_IFID, freeze_pipe,
           hz_state, stall_count
  );

  modport slave (
    input  op1_addr_IFID, op2_addr_IFID, op1_used_IFID, op2_used_IFID,
           dest_addr_EX, reg_wr_en_EX, load_true_EX, branch_taken_EX,
           dmem_req, dmem_ready, perf_clr,
    output stall_PC, stall_IFID, bubble_IDEX, flush_IFID, freeze_pipe,
           hz_state, stall_count
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_detect.sv
// Combinational load-use comparator: flags an ID-stage source that depends on
// a load still in EX. Register 0 is a real register and is compared like any other.
module pipeline_hazard_ctrl_detect
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] op1_addr_i,
  input  logic [REG_ADDR_W-1:0] op2_addr_i,
  input  logic                  op1_used_i,
  input  logic                  op2_used_i,
  input  logic [REG_ADDR_W-1:0] dest_addr_i,
  input  logic                  reg_wr_en_i,
  input  logic                  load_i,
  output logic                  luh_o
);

  logic op1_hit;
  logic op2_hit;

  assign op1_hit = op1_used_i & (op1_addr_i == dest_addr_i);
  assign op2_hit = op2_used_i & (op2_addr_i == dest_addr_i);
  assign luh_o   = load_i & reg_wr_en_i & (op1_hit | op2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use bubbles, taken-branch flush, memory-wait freeze
// and a saturating stall-cycle counter. Outputs are combinational from state and inputs.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int REG_ADDR_W        = DEFAULT_REG_ADDR_W,
  parameter int STALL_CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam bit                    MULTI_STALL = (LOAD_STALL_CYCLES > 1);
  localparam logic [LOAD_CNT_W-1:0] LOAD_RELOAD = LOAD_CNT_W'(LOAD_STALL_CYCLES - 1);

  hz_state_e               state_q, state_d;
  hz_state_e               resume_q, resume_d;
  logic [LOAD_CNT_W-1:0]   cnt_q, cnt_d;
  logic [STALL_CNT_W-1:0]  count_q, count_d;
  hz_ctrl_t                ctrl_d;
  logic                    luh;
  logic                    miss;
  logic                    do_freeze;
  logic                    do_run;
  logic                    do_ls;

  pipeline_hazard_ctrl_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_detect (
    .op1_addr_i  (bus.op1_addr_IFID),
    .op2_addr_i  (bus.op2_addr_IFID),
    .op1_used_i  (bus.op1_used_IFID),
    .op2_used_i  (bus.op2_used_IFID),
    .dest_addr_i (bus.dest_addr_EX),
    .reg_wr_en_i (bus.reg_wr_en_EX),
    .load_i      (bus.load_true_EX),
    .luh_o       (luh)
  );

  assign miss = bus.dmem_req & ~bus.dmem_ready;

  always_comb begin
    ctrl_d    = '0;
    state_d   = state_q;
    resume_d  = resume_q;
    cnt_d     = cnt_q;
    do_freeze = 1'b0;
    do_run    = 1'b0;
    do_ls     = 1'b0;

    unique case (state_q)
      HZ_RUN, HZ_FLUSH: begin
        if (miss) begin
          do_freeze = 1'b1;
          resume_d  = HZ_RUN;
          state_d   = HZ_MEM_WAIT;
        end else if (state_q == HZ_RUN) begin
          do_run = 1'b1;
        end else begin
          // ID holds the flushed NOP, so no hazard check this cycle.
          state_d = HZ_RUN;
        end
      end
      HZ_LOAD_STALL: begin
        if (miss) begin
          do_freeze = 1'b1;
          resume_d  = HZ_LOAD_STALL;
          state_d   = HZ_MEM_WAIT;
        end else begin
          do_ls = 1'b1;
        end
      end
      HZ_MEM_WAIT: begin
        if (!bus.dmem_ready) begin
          do_freeze = 1'b1;
        end else if (resume_q == HZ_LOAD_STALL) begin
          do_ls = 1'b1;
        end else begin
          do_run = 1'b1;
        end
      end
      default: state_d = HZ_RUN;
    endcase

    if (do_freeze) begin
      ctrl_d.freeze_pipe = 1'b1;
      ctrl_d.stall_pc    = 1'b1;
      ctrl_d.stall_ifid  = 1'b1;
    end

    // Branch beats load-use: the stalled ID instruction is being flushed anyway.
    if (do_run) begin
      state_d = HZ_RUN;
      if (bus.branch_taken_EX) begin
        ctrl_d.flush_ifid  = 1'b1;
        ctrl_d.bubble_idex = 1'b1;
        state_d            = HZ_FLUSH;
      end else if (luh) begin
        ctrl_d.stall_pc    = 1'b1;
        ctrl_d.stall_ifid  = 1'b1;
        ctrl_d.bubble_idex = 1'b1;
        if (MULTI_STALL) begin
          cnt_d   = LOAD_RELOAD;
          state_d = HZ_LOAD_STALL;
        end
      end
    end

    if (do_ls) begin
      ctrl_d.stall_pc    = 1'b1;
      ctrl_d.stall_ifid  = 1'b1;
      ctrl_d.bubble_idex = 1'b1;
      if (cnt_q <= LOAD_CNT_W'(1)) begin
        cnt_d   = '0;
        state_d = HZ_RUN;
      end else begin
        cnt_d   = cnt_q - LOAD_CNT_W'(1);
        state_d = HZ_LOAD_STALL;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (bus.perf_clr) begin
      count_d = '0;
    end else if (ctrl_d.stall_pc && !(&count_q)) begin
      count_d = count_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HZ_RUN;
      resume_q <= HZ_RUN;
      cnt_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
    end
  end

  assign bus.stall_PC    = rst_n & ctrl_d.stall_pc;
  assign bus.stall_IFID  = rst_n & ctrl_d.stall_ifid;
  assign bus.bubble_IDEX = rst_n & ctrl_d.bubble_idex;
  assign bus.flush_IFID  = rst_n & ctrl_d.flush_ifid;
  assign bus.freeze_pipe = rst_n & ctrl_d.freeze_pipe;
  assign bus.hz_state    = rst_n ? state_q : HZ_RUN;
  assign bus.stall_count = rst_n ? count_q : '0;

  // EX holds a bubble throughout a load stall, so a taken branch there is a datapath bug.
  assert property (@(posedge clk) disable iff (!rst_n)
                   (state_q == HZ_LOAD_STALL) |-> !bus.branch_taken_EX);

endmodule
